// File: rtl/prog_loader_if.sv
// Keypad-loader bus: decoded key events in, RAM write port and status/display out.
// slave is the loader side; master is the driver/observer side.
interface prog_loader_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic              key_event;
  logic [4:0]        key_code;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_d_in;
  logic              load_active;
  logic              cpu_run;
  logic [WORD_W-1:0] disp_value;
  logic [2:0]        digit_cnt;
  logic              err;

  modport master (
    output key_event, key_code,
    input  ram_we, ram_addr, ram_d_in, load_active, cpu_run, disp_value, digit_cnt, err
  );

  modport slave (
    input  key_event, key_code,
    output ram_we, ram_addr, ram_d_in, load_active, cpu_run, disp_value, digit_cnt, err
  );
endinterface

// File: rtl/prog_loader.sv
// Keypad-driven program writer: assembles hex digits into words and writes them to
// sequential RAM addresses, holding the CPU stopped until DONE.
module prog_loader #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input logic         clock,
  input logic         rst,
  prog_loader_if.slave bus
);

  localparam logic [4:0] KeyEnter   = 5'd16;
  localparam logic [4:0] KeyClear   = 5'd17;
  localparam logic [4:0] KeySetAddr = 5'd18;
  localparam logic [4:0] KeyDone    = 5'd19;
  localparam logic [2:0] MaxDigits  = 3'(WORD_W / 4);

  typedef enum logic [1:0] {StEntry, StWrite, StFull, StRun} state_e;

  state_e            r_state, w_state_d;
  logic [WORD_W-1:0] r_buf, w_buf_d;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_d;
  logic [2:0]        r_digit_cnt, w_digit_cnt_d;
  logic              r_err, w_err_d;

  logic              w_is_digit;
  logic [WORD_W-1:0] w_shifted;
  logic [2:0]        w_cnt_inc;

  assign w_is_digit = bus.key_event && !bus.key_code[4];
  assign w_shifted  = (r_buf << 4) | WORD_W'(bus.key_code[3:0]);
  assign w_cnt_inc  = (r_digit_cnt >= MaxDigits) ? MaxDigits : r_digit_cnt + 3'd1;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= StEntry;
      r_buf       <= '0;
      r_wr_addr   <= '0;
      r_digit_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_buf       <= w_buf_d;
      r_wr_addr   <= w_wr_addr_d;
      r_digit_cnt <= w_digit_cnt_d;
      r_err       <= w_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_buf_d       = r_buf;
    w_wr_addr_d   = r_wr_addr;
    w_digit_cnt_d = r_digit_cnt;
    w_err_d       = r_err;

    unique case (r_state)
      StEntry, StFull: begin
        if (w_is_digit) begin
          w_buf_d       = w_shifted;
          w_digit_cnt_d = w_cnt_inc;
        end else if (bus.key_event) begin
          case (bus.key_code)
            KeyEnter: begin
              // FULL refuses to wrap the address; flag it instead of writing.
              if (r_state == StFull) w_err_d = 1'b1;
              else                   w_state_d = StWrite;
            end
            KeyClear: begin
              w_buf_d       = '0;
              w_digit_cnt_d = '0;
              w_err_d       = 1'b0;
            end
            KeySetAddr: begin
              w_wr_addr_d   = ADDR_W'(r_buf);
              w_buf_d       = '0;
              w_digit_cnt_d = '0;
              w_state_d     = StEntry;
            end
            KeyDone: w_state_d = StRun;
            default: ;
          endcase
        end
      end

      StWrite: begin
        // Keys arriving during the write cycle are dropped.
        w_buf_d       = '0;
        w_digit_cnt_d = '0;
        if (&r_wr_addr) begin
          w_state_d = StFull;
        end else begin
          w_wr_addr_d = r_wr_addr + ADDR_W'(1);
          w_state_d   = StEntry;
        end
      end

      StRun: begin
        if (bus.key_event && bus.key_code == KeyDone) begin
          w_wr_addr_d   = '0;
          w_buf_d       = '0;
          w_digit_cnt_d = '0;
          w_state_d     = StEntry;
        end
      end

      default: w_state_d = StEntry;
    endcase
  end

  assign bus.ram_we      = (r_state == StWrite);
  assign bus.ram_addr    = r_wr_addr;
  assign bus.ram_d_in    = r_buf;
  assign bus.load_active = (r_state != StRun);
  assign bus.cpu_run     = (r_state == StRun);
  assign bus.disp_value  = (r_state == StRun) ? WORD_W'(r_wr_addr) : r_buf;
  assign bus.digit_cnt   = r_digit_cnt;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: constant vector table, hand-written corner
// sequences, and randomized keys against a key-level reference model.
module tb_prog_loader;

  logic clock;
  logic rst;

  prog_loader_if #(.WORD_W(16), .ADDR_W(8)) bus ();

  prog_loader #(.WORD_W(16), .ADDR_W(8)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Observed writes, sampled at the falling edge while ram_we is high.
  logic [7:0]  got_a[$];
  logic [15:0] got_d[$];
  int unsigned rd_idx = 0;

  always @(negedge clock) begin
    if (bus.ram_we) begin
      got_a.push_back(bus.ram_addr);
      got_d.push_back(bus.ram_d_in);
    end
  end

  // Reference model state
  logic [15:0] m_buf;
  logic [7:0]  m_addr;
  int          m_cnt;
  bit          m_err, m_full, m_run;
  logic [7:0]  exp_a[$];
  logic [15:0] exp_d[$];

  typedef struct {
    logic [4:0]  code;
    logic [15:0] disp;
    logic [2:0]  cnt;
    int unsigned nwr;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic model_reset();
    m_buf = '0; m_addr = '0; m_cnt = 0; m_err = 0; m_full = 0; m_run = 0;
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic model_key(input logic [4:0] code, output bit wrote);
    wrote = 0;
    if (m_run) begin
      if (code == 5'd19) begin
        m_run = 0; m_addr = '0; m_buf = '0; m_cnt = 0;
      end
    end else if (code < 5'd16) begin
      m_buf = (m_buf << 4) | 16'(code[3:0]);
      m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
    end else begin
      case (code)
        5'd16: begin
          if (m_full) m_err = 1;
          else begin
            exp_a.push_back(m_addr);
            exp_d.push_back(m_buf);
            wrote = 1;
            m_buf = '0;
            m_cnt = 0;
            if (m_addr == 8'hFF) m_full = 1;
            else m_addr = m_addr + 8'd1;
          end
        end
        5'd17: begin m_buf = '0; m_cnt = 0; m_err = 0; end
        5'd18: begin m_addr = m_buf[7:0]; m_buf = '0; m_cnt = 0; m_full = 0; end
        5'd19: m_run = 1;
        default: ;
      endcase
    end
  endtask

  // Called at a falling edge; holds key_event for exactly one rising edge.
  task automatic press(input logic [4:0] code);
    bus.key_event = 1'b1;
    bus.key_code  = code;
    @(negedge clock);
    bus.key_event = 1'b0;
    bus.key_code  = '0;
  endtask

  task automatic key(input logic [4:0] code);
    bit wrote;
    press(code);
    model_key(code, wrote);
    if (wrote) @(negedge clock);
  endtask

  task automatic check_model(input string tag);
    logic [15:0] exp_disp;
    exp_disp = m_run ? {8'h00, m_addr} : m_buf;
    chk({tag, " disp"}, 32'(bus.disp_value), 32'(exp_disp));
    chk({tag, " cnt"}, 32'(bus.digit_cnt), 32'(m_cnt));
    chk({tag, " err"}, 32'(bus.err), 32'(m_err));
    chk({tag, " load_active"}, 32'(bus.load_active), 32'(!m_run));
    chk({tag, " cpu_run"}, 32'(bus.cpu_run), 32'(m_run));
    chk({tag, " ram_we idle"}, 32'(bus.ram_we), 32'd0);
    chk({tag, " nwrites"}, got_a.size() - rd_idx, exp_a.size());
    foreach (exp_a[i]) begin
      if (rd_idx < got_a.size()) begin
        chk({tag, " wr addr"}, 32'(got_a[rd_idx]), 32'(exp_a[i]));
        chk({tag, " wr data"}, 32'(got_d[rd_idx]), 32'(exp_d[i]));
        rd_idx++;
      end
    end
    exp_a.delete();
    exp_d.delete();
    rd_idx = got_a.size();
  endtask

  task automatic reset_all();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clock);
    model_reset();
    rd_idx = got_a.size();
  endtask

  initial begin
    int r;
    logic [4:0] code;

    tbl = '{
      '{5'd1,  16'h0001, 3'd1, 0}, '{5'd2,  16'h0012, 3'd2, 0},
      '{5'd10, 16'h012A, 3'd3, 0}, '{5'd15, 16'h12AF, 3'd4, 0},
      '{5'd16, 16'h0000, 3'd0, 1},
      '{5'd1,  16'h0001, 3'd1, 1}, '{5'd2,  16'h0012, 3'd2, 1},
      '{5'd3,  16'h0123, 3'd3, 1}, '{5'd4,  16'h1234, 3'd4, 1},
      '{5'd5,  16'h2345, 3'd4, 1}, '{5'd16, 16'h0000, 3'd0, 2},
      '{5'd7,  16'h0007, 3'd1, 2}, '{5'd7,  16'h0077, 3'd2, 2},
      '{5'd17, 16'h0000, 3'd0, 2}
    };

    rst = 1'b1;
    bus.key_event = 1'b0;
    bus.key_code  = '0;
    model_reset();
    #3;
    chk("reset ram_we", 32'(bus.ram_we), 32'd0);
    chk("reset load_active", 32'(bus.load_active), 32'd1);
    chk("reset cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("reset disp", 32'(bus.disp_value), 32'd0);
    chk("reset cnt", 32'(bus.digit_cnt), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    @(negedge clock);
    rst = 1'b0;

    // Vector table: digit entry, saturation, ENTER, CLEAR
    foreach (tbl[i]) begin
      key(tbl[i].code);
      chk($sformatf("tbl[%0d] disp", i), 32'(bus.disp_value), 32'(tbl[i].disp));
      chk($sformatf("tbl[%0d] cnt", i), 32'(bus.digit_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl[%0d] nwr", i), got_a.size() - rd_idx, tbl[i].nwr);
    end
    if (got_a.size() - rd_idx == 2) begin
      chk("tbl wr0 addr", 32'(got_a[rd_idx]), 32'h00);
      chk("tbl wr0 data", 32'(got_d[rd_idx]), 32'h12AF);
      chk("tbl wr1 addr", 32'(got_a[rd_idx+1]), 32'h01);
      chk("tbl wr1 data", 32'(got_d[rd_idx+1]), 32'h2345);
    end
    check_model("tbl");

    // Reset in the middle of a write cycle
    key(5'd1);
    key(5'd2);
    press(5'd16);
    chk("midwr ram_we before rst", 32'(bus.ram_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midwr ram_we", 32'(bus.ram_we), 32'd0);
    chk("midwr disp", 32'(bus.disp_value), 32'd0);
    chk("midwr cnt", 32'(bus.digit_cnt), 32'd0);
    chk("midwr load_active", 32'(bus.load_active), 32'd1);
    chk("midwr cpu_run", 32'(bus.cpu_run), 32'd0);
    @(negedge clock);
    rst = 1'b0;
    model_reset();
    rd_idx = got_a.size();
    key(5'd19);
    chk("midwr wr_addr", 32'(bus.disp_value), 32'h0000);
    key(5'd19);
    check_model("midwr");

    // Address setting, top-of-RAM FULL, err set/clear
    reset_all();
    key(5'd15); key(5'd14); key(5'd18); key(5'd0); key(5'd9); key(5'd16);
    key(5'd1); key(5'd16);
    chk("full nwr", got_a.size() - rd_idx, 2);
    if (got_a.size() - rd_idx == 2) begin
      chk("full wr0 addr", 32'(got_a[rd_idx]), 32'hFE);
      chk("full wr0 data", 32'(got_d[rd_idx]), 32'h0009);
      chk("full wr1 addr", 32'(got_a[rd_idx+1]), 32'hFF);
      chk("full wr1 data", 32'(got_d[rd_idx+1]), 32'h0001);
    end
    check_model("full a");
    key(5'd16);
    chk("full enter err", 32'(bus.err), 32'd1);
    check_model("full b");
    key(5'd17);
    chk("full clear err", 32'(bus.err), 32'd0);
    check_model("full c");

    // RUN mode
    reset_all();
    key(5'd5); key(5'd16); key(5'd6); key(5'd16);
    key(5'd19);
    chk("run load_active", 32'(bus.load_active), 32'd0);
    chk("run cpu_run", 32'(bus.cpu_run), 32'd1);
    chk("run disp", 32'(bus.disp_value), 32'h0002);
    key(5'd3); key(5'd16);
    chk("run disp after keys", 32'(bus.disp_value), 32'h0002);
    check_model("run a");
    key(5'd19);
    key(5'd7); key(5'd16);
    check_model("run b");

    // ENTER during WRITE is dropped; ignored codes do nothing
    reset_all();
    key(5'd4);
    press(5'd16);
    begin
      bit wrote;
      model_key(5'd16, wrote);
    end
    press(5'd16);
    chk("drop nwr", got_a.size() - rd_idx, 1);
    check_model("drop");
    key(5'd8);
    key(5'd25);
    chk("ignore disp", 32'(bus.disp_value), 32'h0008);
    check_model("ignore");

    // Randomized keys against the model
    reset_all();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(99, 0));
      if (r < 55)      code = 5'($urandom_range(15, 0));
      else if (r < 68) code = 5'd16;
      else if (r < 76) code = 5'd17;
      else if (r < 85) code = 5'd18;
      else if (r < 92) code = 5'd19;
      else             code = 5'($urandom_range(31, 20));
      key(code);
      check_model($sformatf("rnd[%0d]", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
